// File: rtl/dev_timer_pkg.sv
// Shared definitions for the memory-mapped interval timer: register offsets,
// CTRL bit positions, MODE encodings and FSM state codes.
package dev_timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

endpackage

// File: rtl/dev_timer.sv
// Interval timer on the device bus: writes land on the rising edge, reads are
// combinational with no wait state; the interrupt comes only from flops.
module dev_timer
    import dev_timer_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  DEV_Addr,
    input  logic [31:0] DEV_WD,
    input  logic        DEV_WE,
    output logic [31:0] DEV_RD,
    output logic        DEV_IRQ
);

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        pending;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_mode;

    assign wr_ctrl   = DEV_WE && (DEV_Addr == ADDR_CTRL);
    assign wr_preset = DEV_WE && (DEV_Addr == ADDR_PRESET);
    // Only MODE=01 reloads; 10/11 fall back to one-shot behaviour.
    assign auto_mode = (ctrl_mode == MODE_AUTO);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl_en) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CNT;
            ST_CNT: begin
                if (!ctrl_en)
                    state_nxt = ST_IDLE;
                else if (count == 32'd0)
                    state_nxt = ST_INT;
            end
            ST_INT:  state_nxt = auto_mode ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A bus write to CTRL takes priority over the one-shot self-disable.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= DEV_WD[CTRL_EN];
            ctrl_mode <= DEV_WD[CTRL_MODE_HI:CTRL_MODE_LO];
            ctrl_im   <= DEV_WD[CTRL_IM];
        end else if (state == ST_INT && !auto_mode) begin
            ctrl_en   <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= DEV_WD;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= 32'd0;
        end else if (state == ST_LOAD) begin
            count <= preset;
        end else if (state == ST_CNT && ctrl_en && count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    // Entering INT wins over a same-edge register write; otherwise any
    // CTRL/PRESET write acknowledges, and auto-reload self-clears on exit.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pending <= 1'b0;
        end else if (state == ST_CNT && state_nxt == ST_INT) begin
            pending <= 1'b1;
        end else if (wr_ctrl || wr_preset) begin
            pending <= 1'b0;
        end else if (state == ST_INT && auto_mode) begin
            pending <= 1'b0;
        end
    end

    assign DEV_IRQ = ctrl_im & pending;

    always_comb begin
        DEV_RD = 32'd0;
        case (DEV_Addr)
            ADDR_CTRL:   DEV_RD = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            ADDR_PRESET: DEV_RD = preset;
            ADDR_COUNT:  DEV_RD = count;
            default:     DEV_RD = 32'd0;
        endcase
    end

endmodule

// File: doc/dev_timer.md
# dev_timer

Memory-mapped interval timer that answers the CPU's device-bus cycles and raises a hardware interrupt. It sits behind the system bridge. It decodes the word offset and write enable the bridge forwards from the CPU's memory-stage address and store data, and it returns read data on the same bus. Its interrupt output feeds one bit of the CPU's HWInt[7:2] vector.

## Interface
Parameters: none.

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low; the block is in reset while Reset=0
- DEV_Addr  in  2  word offset within the device window (CPU address bits [3:2])
- DEV_WD  in  32  write data from the CPU store path
- DEV_WE  in  1  write strobe, already qualified by the bridge for this device
- DEV_RD  out  32  read data, combinational from DEV_Addr
- DEV_IRQ  out  1  interrupt request to the bridge/CP0

## Operation
Register map:
- 0: CTRL. Bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00 but read back as written), [3] IM. Bits [31:4] read 0.
- 1: PRESET, read/write, 32 bits.
- 2: COUNT, read-only; writes are ignored.
- 3: reads 0; writes are ignored.

Bus behaviour:
- When DEV_WE=1, the addressed register is written at the rising edge.
- DEV_RD shows the currently stored value of the addressed register with no wait state.

FSM (states IDLE, LOAD, CNT, INT):
- IDLE: if EN=1, go to LOAD.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - If EN=0, go to IDLE and COUNT holds.
  - Otherwise, if COUNT==0, go to INT.
  - Otherwise, COUNT <= COUNT-1.
- INT:
  - MODE one-shot: EN <= 0 and go to IDLE.
  - MODE auto-reload: go to LOAD and EN is unchanged.
- Pending flag:
  - Set on every transition into INT.
  - In one-shot mode it stays set until any write to CTRL or PRESET.
  - In auto-reload mode it clears on leaving INT.
- DEV_IRQ = IM & pending. This output is registered-derived and has no combinational path from the bus.
- Arithmetic is 32-bit unsigned. COUNT never wraps because decrement only happens when COUNT != 0.

## Timing
- Reset values:
  - CTRL=0, PRESET=0, COUNT=0.
  - State IDLE, pending=0, DEV_IRQ=0.
  - DEV_RD=0 for every address.
- Start-up: a CTRL write with EN=1 at edge E gives the following sequence.
  - LOAD after E+1.
  - COUNT=PRESET=P after E+2.
  - COUNT=0 after E+2+P.
  - INT with DEV_IRQ=1 after E+3+P.
- Auto-reload period is P+3 cycles. DEV_IRQ is high for exactly 1 cycle per period.
- One-shot: DEV_IRQ rises after E+3+P and holds until a CTRL/PRESET write edge. EN reads 0 from E+4+P.
- Same-edge collision, CTRL write in INT: the bus write wins for EN, and pending is cleared.
- A PRESET write during CNT does not alter COUNT; it takes effect at the next LOAD.
- EN cleared during CNT freezes COUNT. Re-enabling reloads from PRESET; it does not resume.
- Reset asserted mid-count returns every register to its reset value immediately, independent of Clk.

## Structure
- Shared package holds:
  - register offsets (CTRL=0, PRESET=1, COUNT=2);
  - CTRL bit positions;
  - MODE encodings;
  - the FSM state encoding.
- The design is a single module. The register file is small enough that a separate sub-module is not warranted.

## Test plan
- Reset with all registers written nonzero, then pull Reset low asynchronously. Required: DEV_RD=0 at offsets 0/1/2 and DEV_IRQ=0 before the next Clk edge.
- One-shot: write PRESET=5, then CTRL=0b1001. Required: DEV_IRQ rises 8 edges after the CTRL write and stays high; CTRL reads 0x8 afterwards; a CTRL write of 0 drops DEV_IRQ.
- Auto-reload: write PRESET=3, then CTRL=0b1011. Required: DEV_IRQ is a 1-cycle pulse every 6 cycles for at least 4 periods; COUNT readback follows 3,2,1,0.
- Mask: same as the one-shot case with IM=0. Required: DEV_IRQ stays 0; COUNT reaches 0 and EN clears.
- Pause and PRESET update: during CNT with COUNT=10, write CTRL.EN=0 and then PRESET=2. Required: COUNT holds at 10. Then re-enable. Required: COUNT=2 at the LOAD exit and the interrupt fires 5 edges after the enable write.
- Edge case: PRESET=0 in one-shot. Required: DEV_IRQ 3 edges after enable. Also check that a write to offset 2 or 3 changes nothing.
